// File: rtl/hex_display_bank.sv
// hex_display_bank
//   Drives NUM_DIGITS seven-segment digits from one latched word of nibbles.
//   Each digit can be blanked, blinked, or suppressed as a leading zero.
//   The pins are registered. A value sampled with load=1 reaches hex two
//   edges after the sample.
//
// Ports
//   clk         in   rising-edge system clock
//   reset       in   asynchronous, active-high; clears all state, hex goes dark
//   load        in   1: capture value/blank_mask/blink_mask/lz_en this edge
//   value       in   4*NUM_DIGITS  nibble i drives digit i (digit 0 = LSN)
//   blank_mask  in   NUM_DIGITS    bit i=1: digit i always dark
//   blink_mask  in   NUM_DIGITS    bit i=1: digit i dark in the blink off phase
//   lz_en       in   1: suppress leading zeros (digit 0 is never suppressed)
//   hex         out  7*NUM_DIGITS  hex[7i+6:7i] = segments g..a of digit i
//
// Handshake: there is no back-pressure. load is a one-cycle strobe sampled
// on every rising edge. The shadow registers hold while load=0.
module hex_display_bank #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25_000_000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_en,
  output logic [7*NUM_DIGITS-1:0] hex
);

  localparam int            CW       = $clog2(BLINK_DIV + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(BLINK_DIV - 1);
  localparam logic [6:0]    DARK_PIN = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  // Active-low segment code, bits g..a.
  function automatic logic [6:0] seg_code(input logic [3:0] n);
    logic [6:0] c;
    case (n)
      4'h0: c = 7'h40;
      4'h1: c = 7'h79;
      4'h2: c = 7'h24;
      4'h3: c = 7'h30;
      4'h4: c = 7'h19;
      4'h5: c = 7'h12;
      4'h6: c = 7'h02;
      4'h7: c = 7'h58;
      4'h8: c = 7'h00;
      4'h9: c = 7'h10;
      4'hA: c = 7'h08;
      4'hB: c = 7'h03;
      4'hC: c = 7'h27;
      4'hD: c = 7'h21;
      4'hE: c = 7'h06;
      default: c = 7'h0E;
    endcase
    return c;
  endfunction

  // Shadow registers. They are written only on load and cleared by reset.
  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   blank_q;
  logic [NUM_DIGITS-1:0]   blink_q;
  logic                    lz_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
      blank_q <= '0;
      blink_q <= '0;
      lz_q    <= 1'b0;
    end else if (load) begin
      value_q <= value;
      blank_q <= blank_mask;
      blink_q <= blink_mask;
      lz_q    <= lz_en;
    end
  end

  // Free-running blink timer. load does not touch it, so a reload never
  // shifts the blink edge.
  logic [CW-1:0] blink_cnt;
  logic          phase_off;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      phase_off <= 1'b0;
    end else if (blink_cnt == CNT_MAX) begin
      blink_cnt <= '0;
      phase_off <= ~phase_off;
    end else begin
      blink_cnt <= blink_cnt + CW'(1);
    end
  end

  // Digit decode. The scan runs from the top digit down, and zero_run
  // tracks whether every nibble from the top through the current digit is
  // zero. It uses the raw value, so blanking a digit does not change which
  // digits count as leading.
  logic [7*NUM_DIGITS-1:0] hex_d;
  logic [3:0]              nib;
  logic                    zero_run;
  logic                    dark;
  logic [6:0]              code;

  always_comb begin
    hex_d    = '0;
    nib      = 4'h0;
    zero_run = 1'b1;
    dark     = 1'b0;
    code     = 7'h7F;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib      = value_q[4*i +: 4];
      zero_run = zero_run & (nib == 4'h0);
      dark     = blank_q[i] | (lz_q & (i > 0) & zero_run) | (blink_q[i] & phase_off);
      code     = dark ? 7'h7F : seg_code(nib);
      hex_d[7*i +: 7] = (ACTIVE_LOW != 0) ? code : ~code;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex <= {NUM_DIGITS{DARK_PIN}};
    end else begin
      hex <= hex_d;
    end
  end

endmodule

// File: tb/tb_hex_display_bank.sv
// Bench for hex_display_bank.
//   dut : NUM_DIGITS=6, BLINK_DIV=4, ACTIVE_LOW=1
//   dut2: NUM_DIGITS=1, BLINK_DIV=4, ACTIVE_LOW=0
// The reference model keeps its own copy of the latched fields. It derives
// the blink phase from the number of edges since reset, and decides
// leading-zero suppression by shifting the value.
module tb_hex_display_bank;
  localparam int N   = 6;
  localparam int DIV = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load = 1'b0;
  logic [23:0]   value = '0;
  logic [5:0]    blank_mask = '0;
  logic [5:0]    blink_mask = '0;
  logic          lz_en = 1'b0;
  logic [41:0]   hex;

  logic          load2 = 1'b0;
  logic [3:0]    value2 = '0;
  logic          blank2 = 1'b0;
  logic          blink2 = 1'b0;
  logic          lz2 = 1'b0;
  logic [6:0]    hex2;

  always #5 clk = ~clk;

  hex_display_bank #(.NUM_DIGITS(N), .BLINK_DIV(DIV), .ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .load(load), .value(value),
    .blank_mask(blank_mask), .blink_mask(blink_mask), .lz_en(lz_en), .hex(hex)
  );

  hex_display_bank #(.NUM_DIGITS(1), .BLINK_DIV(DIV), .ACTIVE_LOW(0)) dut2 (
    .clk(clk), .reset(reset), .load(load2), .value(value2),
    .blank_mask(blank2), .blink_mask(blink2), .lz_en(lz2), .hex(hex2)
  );

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h58,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [41:0] act, input logic [41:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (dut) ----------------
  function automatic logic [41:0] model_hex(input logic [23:0] v, input logic [5:0] bl,
                                            input logic [5:0] bk, input logic lz, input logic off);
    logic [41:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      logic [23:0] upper;
      logic        lead;
      logic        dk;
      upper = v >> (4 * i);
      lead  = lz && (i > 0) && (upper == 24'd0);
      dk    = bl[i] || lead || (bk[i] && off);
      r[7*i +: 7] = dk ? 7'h7F : seg_tab[upper[3:0]];
    end
    return r;
  endfunction

  logic [23:0] m_val;
  logic [5:0]  m_blank, m_blink;
  logic        m_lz;
  int unsigned m_edges;
  logic [41:0] m_exp;

  // The phase flips after every DIV edges since reset, so it is off when
  // (edges / DIV) is odd.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_val <= '0; m_blank <= '0; m_blink <= '0; m_lz <= 1'b0;
      m_edges <= 0;
      m_exp <= '1;
    end else begin
      m_exp <= model_hex(m_val, m_blank, m_blink, m_lz, ((m_edges / DIV) % 2) == 1);
      if (load) begin
        m_val <= value; m_blank <= blank_mask; m_blink <= blink_mask; m_lz <= lz_en;
      end
      m_edges <= m_edges + 1;
    end
  end

  // One clock; compare dut against the model on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check("model", hex, m_exp);
  endtask

  task automatic load_word(input logic [23:0] v, input logic [5:0] bl, input logic [5:0] bk,
                           input logic lz);
    load = 1'b1; value = v; blank_mask = bl; blink_mask = bk; lz_en = lz;
    step();
    load = 1'b0;
    value = 24'($urandom); blank_mask = 6'($urandom); blink_mask = 6'($urandom); lz_en = 1'($urandom);
  endtask

  typedef struct {
    logic [23:0] v;
    logic [5:0]  bl;
    logic        lz;
    logic [41:0] exp;
  } vec_t;

  vec_t tv [7];
  logic [6:0] exp_q [$];

  initial begin
    tv[0] = '{24'h0123AF, 6'b000000, 1'b0, {7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h0E}};
    tv[1] = '{24'h000A05, 6'b000000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40, 7'h12}};
    tv[2] = '{24'h000000, 6'b000000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
    tv[3] = '{24'h111111, 6'b100001, 1'b0, {7'h7F, 7'h79, 7'h79, 7'h79, 7'h79, 7'h7F}};
    tv[4] = '{24'h000A05, 6'b000100, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h12}};
    tv[5] = '{24'h800000, 6'b000000, 1'b1, {7'h00, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
    tv[6] = '{24'h000000, 6'b000000, 1'b0, {6{7'h40}}};

    // Reset: all segments dark, asynchronously.
    #1 reset = 1'b1;
    #2;
    check("reset_dark", hex, {42{1'b1}});
    check("reset_dark2", {35'd0, hex2}, 42'd0);
    @(negedge clk);
    step();
    reset = 1'b0;
    step();
    check("first_after_reset", hex, {6{7'h40}});

    // Table vectors: load, then check two edges later.
    for (int i = 0; i < 7; i++) begin
      load_word(tv[i].v, tv[i].bl, 6'b0, tv[i].lz);
      step();
      check($sformatf("vec%0d", i), hex, tv[i].exp);
    end

    // Sweep every nibble code on every digit.
    for (int n = 0; n < 16; n++) begin
      logic [3:0] nb;
      nb = n[3:0];
      load_word({6{nb}}, 6'b0, 6'b0, 1'b0);
      step();
      check($sformatf("sweep%0d", n), hex, {6{seg_tab[n]}});
    end

    // Blink on digits 1..0. A reload mid-period must not move the toggle.
    load_word(24'h111111, 6'b0, 6'b000011, 1'b0);
    for (int t = 0; t < 6; t++) step();
    load_word(24'h111111, 6'b0, 6'b000011, 1'b0);
    for (int t = 0; t < 12; t++) begin
      step();
      check("blink_upper_steady", {14'd0, hex[41:14]}, {14'd0, {4{7'h79}}});
    end

    // Blank overrides blink: digits 5 and 0 stay dark in both phases.
    load_word(24'h111111, 6'b100001, 6'b000001, 1'b0);
    for (int t = 0; t < 10; t++) begin
      step();
      if (t > 0) check("blank_over_blink", {28'd0, hex[41:35], hex[6:0]}, {28'd0, 7'h7F, 7'h7F});
    end

    // Randomized traffic against the model.
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        logic [23:0] rv;
        rv = 24'($urandom) & ((24'd1 << (4 * $urandom_range(0, 6))) - 24'd1);
        if ($urandom_range(0, 3) == 0) rv = 24'($urandom);
        load = 1'b1; value = rv;
        blank_mask = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
        blink_mask = 6'($urandom);
        lz_en = 1'($urandom);
      end else begin
        load = 1'b0; value = 24'($urandom);
      end
      step();
    end
    load = 1'b0;

    // Active-high single digit.
    load2 = 1'b1; value2 = 4'h8;
    step();
    load2 = 1'b0; value2 = 4'h3;
    step();
    check("ah_eight", {35'd0, hex2}, {35'd0, 7'h7F});

    // Mid-run reset between clock edges.
    #2 reset = 1'b1;
    #1;
    check("midrun_reset", hex, {42{1'b1}});
    check("midrun_reset2", {35'd0, hex2}, 42'd0);
    @(negedge clk);
    reset = 1'b0;
    step();
    check("after_midrun_reset", hex, {6{7'h40}});

    // load held high with a new value every cycle: two-edge latency.
    load2 = 1'b1;
    for (int t = 0; t < 20; t++) begin
      int unsigned v;
      if (t >= 2) check("ah_pipeline", {35'd0, hex2}, {35'd0, exp_q.pop_front()});
      v = $urandom_range(0, 15);
      value2 = v[3:0];
      exp_q.push_back(~seg_tab[v]);
      step();
    end
    load2 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
